gf180mcu_fd_sc_mcu7t5v0__inv_pipe: RTL
======================================

Name: gf180mcu_fd_sc_mcu7t5v0__inv_pipe

Overview:
Parametrised, registered successor to the single-bit combinational inverter cell. Carries a WIDTH-bit word through DEPTH register stages with valid/ready flow control. Each word is inverted under a per-transaction polarity-selectable mask. Used as a timing-closure and retiming element on wide inverted buses in the 7-track 5 V MCU library, where the plain inverter cell cannot break long paths.

Parameters:
WIDTH, 8, data width in bits (1..64)
DEPTH, 2, number of register stages (1..8); a DEPTH of 0 is illegal and must fail elaboration
INV_MASK, {WIDTH{1'b1}}, bits inverted when POL=1; bits not in the mask pass through unchanged

Ports:
CLK  input  1  clock, rising edge
RN  input  1  asynchronous active-low reset
I  input  WIDTH  input data word
POL  input  1  polarity for this word: 1 = apply INV_MASK, 0 = pass all bits unmodified
IV  input  1  input valid
IR  output  1  input ready
ZN  output  WIDTH  output data word (registered)
ZV  output  1  output valid (registered)
ZR  input  1  downstream ready
FLUSH  input  1  synchronous discard of all in-flight words
CNT  output  $clog2(DEPTH+1)  number of valid stages

Behaviour:
- Clock and reset are decided: one clock, CLK; reset RN is asynchronous and active-low.
- Transform at acceptance: stored = POL ? (I ^ INV_MASK) : I. The transform is applied once, in stage 0; later stages only copy.
- Each stage k holds data_k and v_k. ZN = data_{DEPTH-1}, ZV = v_{DEPTH-1}.
- Advance rule: stage k loads from stage k-1 when (!v_k || stage k empties this cycle).
  - The last stage empties when ZV && ZR.
  - Ready ripples combinationally from ZR back to IR: IR = !v_0 || stage 0 advances.
- Accept: IV && IR. Output transfer: ZV && ZR.
- Latency: a word accepted at edge n appears on ZN/ZV after edge n+DEPTH-1, provided no stall occurs.
  - Bubbles collapse, so stages drain forward even while ZR=0.
- Throughput: one word per cycle when full, with ZR=1 and IV=1. Accept and transfer in the same edge leave CNT unchanged.
- Stall hold: while ZV=1 and ZR=0, ZN and ZV stay stable until the transfer.
- CNT: +1 on accept only, -1 on transfer only, unchanged on both or neither. Range 0..DEPTH.
- Full (CNT=DEPTH) with ZR=0 gives IR=0. Empty gives ZV=0.
- FLUSH=1:
  - IR=0 combinationally.
  - At the next edge all v_k clear, CNT goes to 0 and ZV goes to 0. Data registers keep their values.
  - Any accept or transfer in that cycle is ignored, because FLUSH has priority.
  - A word presented with FLUSH high is not accepted.
- Reset (RN=0, asynchronous, including mid-transfer):
  - All v_k, data_k, ZN, ZV and CNT go to 0. IR is forced to 0 while RN=0.
  - The first accept is allowed at the first edge after RN deasserts.
- X on I is permitted when IV=0. X on IV, ZR or FLUSH out of reset is a bench error.

Optional Feature:
Macro GF180MCU_FD_SC_MCU7T5V0_INV_PIPE_SCAN_EN.
- Defined: adds ports SE (input 1), SI (input 1) and SO (output 1).
  - While SE=1, every data and valid register forms one shift chain, ordered SI -> v_0, data_0[0..WIDTH-1], v_1, ... -> SO. One bit shifts per edge.
  - While SE=1: IR=0, ZV is driven from the chain register, and CNT is recomputed from the valid bits.
  - RN still has priority over SE.
- Undefined: SE, SI and SO do not exist, and behaviour is exactly as above.

Test Plan:
1. WIDTH=8, DEPTH=3, mask 8'hFF, ZR=1: send I=8'h5A POL=1 -> ZN=8'hA5 and ZV=1 exactly 2 edges after accept (DEPTH-1); then I=8'h5A POL=0 -> ZN=8'h5A.
2. Mask 8'h0F: I=8'h33 POL=1 -> ZN=8'h3C.
3. ZR=0, push 4 words -> IR=0 after the 3rd accept, CNT=3, ZN holds the first word. Raise ZR with IV=1 -> 1 word per cycle, CNT stays 3.
4. Pipe holding 2 words, assert FLUSH while IV=1 -> IR=0, nothing accepted; next edge CNT=0, ZV=0.
5. Assert RN=0 between edges with CNT=2 -> ZV, ZN and CNT go to 0 immediately. After release, I=8'h00 POL=1 -> ZN=8'hFF.
6. With the scan macro defined: SE=1, shift 3*(8+1)=27 bits of the pattern 1,0,1,... into SI -> the same sequence emerges on SO starting 27 edges later.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__inv_pipe.sv
// Registered, valid/ready flow-controlled masked-inverter pipeline of DEPTH stages.
// Optional scan chain (SE/SI/SO) enabled by defining GF180MCU_FD_SC_MCU7T5V0_INV_PIPE_SCAN_EN.
module gf180mcu_fd_sc_mcu7t5v0__inv_pipe #(
    parameter int               WIDTH    = 8,
    parameter int               DEPTH    = 2,
    parameter logic [WIDTH-1:0] INV_MASK = {WIDTH{1'b1}}
) (
    input  logic                         CLK,
    input  logic                         RN,
    input  logic [WIDTH-1:0]             I,
    input  logic                         POL,
    input  logic                         IV,
    output logic                         IR,
    output logic [WIDTH-1:0]             ZN,
    output logic                         ZV,
    input  logic                         ZR,
    input  logic                         FLUSH,
    output logic [$clog2(DEPTH+1)-1:0]   CNT
`ifdef GF180MCU_FD_SC_MCU7T5V0_INV_PIPE_SCAN_EN
    ,
    input  logic                         SE,
    input  logic                         SI,
    output logic                         SO
`endif
);

    localparam int CNT_W = $clog2(DEPTH+1);

    if (DEPTH < 1 || DEPTH > 8) begin : g_depth_check
        $error("gf180mcu_fd_sc_mcu7t5v0__inv_pipe: DEPTH must be in 1..8");
    end
    if (WIDTH < 1 || WIDTH > 64) begin : g_width_check
        $error("gf180mcu_fd_sc_mcu7t5v0__inv_pipe: WIDTH must be in 1..64");
    end

    function automatic logic [WIDTH-1:0] apply_mask(input logic [WIDTH-1:0] word,
                                                    input logic             pol);
        return pol ? (word ^ INV_MASK) : word;
    endfunction

    logic [WIDTH-1:0] data_p [DEPTH];
    logic [DEPTH-1:0] vld_p;
    logic [DEPTH-1:0] adv;
    logic             scan_on;
    logic             acc;
    logic [CNT_W-1:0] cnt_c;

`ifdef GF180MCU_FD_SC_MCU7T5V0_INV_PIPE_SCAN_EN
    localparam int CHAIN_W = DEPTH * (WIDTH + 1);

    logic [CHAIN_W-1:0] chain_q;
    logic [CHAIN_W-1:0] chain_d;

    // Chain order from SI: v_0, data_0[0..WIDTH-1], v_1, data_1[...], ... -> SO.
    always_comb begin
        chain_q = '0;
        for (int k = 0; k < DEPTH; k++) begin
            chain_q[k*(WIDTH+1)]            = vld_p[k];
            chain_q[k*(WIDTH+1)+1 +: WIDTH] = data_p[k];
        end
        chain_d = {chain_q[CHAIN_W-2:0], SI};
    end

    assign SO      = chain_q[CHAIN_W-1];
    assign scan_on = SE;
`else
    assign scan_on = 1'b0;
`endif

    // A stage may load when it, or any stage downstream of it, is empty, or the output drains.
    always_comb begin
        logic room;
        adv  = '0;
        room = ZR;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            room   = room || !vld_p[k];
            adv[k] = room;
        end
    end

    assign IR  = RN && !FLUSH && !scan_on && adv[0];
    assign acc = IV && IR;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            vld_p <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_p[k] <= '0;
            end
        end
`ifdef GF180MCU_FD_SC_MCU7T5V0_INV_PIPE_SCAN_EN
        else if (SE) begin
            for (int k = 0; k < DEPTH; k++) begin
                vld_p[k]  <= chain_d[k*(WIDTH+1)];
                data_p[k] <= chain_d[k*(WIDTH+1)+1 +: WIDTH];
            end
        end
`endif
        else if (FLUSH) begin
            vld_p <= '0;
        end
        else begin
            // Stage 0: the only place the mask is applied.
            if (adv[0]) begin
                vld_p[0] <= acc;
                if (acc) begin
                    data_p[0] <= apply_mask(I, POL);
                end
            end
            // Stages 1..DEPTH-1: plain copy from the previous stage.
            for (int k = 1; k < DEPTH; k++) begin
                if (adv[k]) begin
                    vld_p[k] <= vld_p[k-1];
                    if (vld_p[k-1]) begin
                        data_p[k] <= data_p[k-1];
                    end
                end
            end
        end
    end

    always_comb begin
        cnt_c = '0;
        for (int k = 0; k < DEPTH; k++) begin
            cnt_c = cnt_c + CNT_W'(vld_p[k]);
        end
    end

    assign CNT = cnt_c;
    assign ZN  = data_p[DEPTH-1];
    assign ZV  = vld_p[DEPTH-1];

endmodule
